run_detect_arbiter: RTL and testbench
=====================================

# run_detect_arbiter

Round-robin scheduler that shares one serial run detector among N_REQ requesters. Each granted requester's WIDTH-bit word is shifted LSB-first through an embedded Mealy run detector, and the number of long-run hits is reported back. The block sits between parallel word producers and the lab's serial pattern-detection datapath. Only one word is processed at a time.

## Interface
- N_REQ, 4, number of requesters; legal range 2..8.
- WIDTH, 8, bits per word; legal range 4..16.
- CLK  in  1  rising-edge clock.
- nRESET  in  1  reset: asynchronous, active-low.
- req  in  N_REQ  per-requester request level.
- data  in  N_REQ*WIDTH  word for requester k on data[k*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant; high for the whole shift phase.
- busy  out  1  high while in SHIFT or DONE.
- done  out  1  one-cycle pulse when the result is valid.
- done_id  out  clog2(N_REQ)  index of the requester just served; valid with done.
- hits  out  4  hit count for the served word; updated on entry to DONE, held otherwise.

## Operation
- Top FSM: IDLE, SHIFT, DONE.
  - IDLE: if req != 0 at a clock edge, pick the winner, set gnt, capture data[winner] into the shift register, clear bitcnt and the hit counter, set the detector to INIT, and go to SHIFT.
  - SHIFT: each edge feeds shreg[0] to the detector, shifts right, increments bitcnt, and increments the hit counter when the detector output is 1. After WIDTH bits, go to DONE: gnt=0, done=1, hits and done_id loaded.
  - DONE: go to IDLE on the next edge.
- Arbitration is round-robin. The last-served pointer resets to N_REQ-1, so requester 0 has first priority. The search order is last+1, last+2, … mod N_REQ. The pointer updates to the winner at grant.
- req is sampled only in IDLE.
  - Dropping req during SHIFT does not abort the word.
  - A requester still holding req after its done re-enters arbitration at lowest priority.
- Detector states: INIT, ONE1, ONE2, ONE3, ZERO1, ZERO2, ZERO3.
  - Bit 1 moves INIT, any ZEROx, ONE1 or ONE2 to the next ONE state (INIT→ONE1, ZEROx→ONE1, ONE1→ONE2, ONE2→ONE3). ONE3 stays in ONE3.
  - Bit 0 is symmetric over the ZERO states.
  - Output (combinational on the current bit) = 1 only for bit 1 in ONE3 or bit 0 in ZERO3. Every bit from the 4th consecutive equal bit onward is a hit.
  - Unused state encodings go to INIT with output 0.
- Hit counter: 4 bits. Maximum value is WIDTH-3 (at most 13), so it cannot overflow.

## Timing
- Reset values: gnt=0, busy=0, done=0, done_id=0, hits=0, FSM=IDLE, detector=INIT, pointer=N_REQ-1.
- Reset mid-operation: all outputs return to reset values immediately, the pending word is discarded, and no done is issued.
- Let E0 be the IDLE edge that sees a request.
  - gnt and busy are high after E0.
  - Bit i is consumed at edge E(i+1).
  - done and hits are valid after E(WIDTH), for exactly one cycle.
  - The FSM is back in IDLE after E(WIDTH+1), and the next grant can occur at E(WIDTH+2).
  - Back-to-back service period is WIDTH+2 cycles.
- Simultaneous requests at E0: exactly one gnt bit is set, chosen by the pointer. The others wait; no request is lost while its req stays high.
- data must be stable only at E0. It is captured at the grant edge.
- Outputs are registered; there is no combinational path from req or data to any output.

## Test plan
1. req=0001, data0=8'hFF → gnt=0001 for 8 cycles, then done=1 with done_id=0 and hits=5. Check done lands 8 cycles after gnt rises.
2. req=0001, data0=8'h0F → hits=2: one hit on bit 3, one on bit 7. Confirms the ONE3→ZERO1 transition.
3. req=0001, data0=8'hAA → hits=0. Then data0=8'h00 → hits=5.
4. All four requests held from reset with distinct words → grants in order 0, 1, 2, 3, 0. Check done_id matches each grant, the done pulses are 10 cycles apart, and each hits value matches its word.
5. Only req1 and req3 held → grants alternate 1, 3, 1, 3. Dropping req1 during its SHIFT still yields a done for requester 1.
6. nRESET low during bit 3 of a word → gnt, busy and done go to 0 immediately. After release with req0 still high, a full word is processed, gnt=0001 first, and the correct hits is reported.

Source files
------------

// File: rtl/run_detect_arbiter_if.sv
// Handshake/bus bundle between the word producers and run_detect_arbiter.
// Latency: none, wires only.
// Backpressure: none; req is a level that is held until the requester is served.
// Ports: req/data (producer -> arbiter); gnt/busy/done/done_id/hits (arbiter -> producer).
interface run_detect_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] data;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   done;
    logic [IDW-1:0]         done_id;
    logic [3:0]             hits;

    modport master (
        output req, data,
        input  gnt, busy, done, done_id, hits
    );

    modport slave (
        input  req, data,
        output gnt, busy, done, done_id, hits
    );
endinterface

// File: rtl/run_detect_arbiter.sv
// Round-robin shares one serial Mealy run detector among N_REQ word producers.
// Latency: grant at the first edge seeing req, done/hits WIDTH edges later, WIDTH+2 cycle service period.
// Backpressure: req held high waits for a grant; req is sampled only while idle.
// Ports: CLK, nRESET (async, active-low); bus.req/bus.data in; bus.gnt/busy/done/done_id/hits out (all registered).
module run_detect_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input logic               CLK,
    input logic               nRESET,
    run_detect_arbiter_if.slave bus
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BCW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [2:0] {D_INIT, D_ONE1, D_ONE2, D_ONE3, D_ZERO1, D_ZERO2, D_ZERO3} det_t;

    state_t           state_q,  state_d;
    det_t             det_q,    det_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic [3:0]       cnt_q,    cnt_d;
    logic [IDW-1:0]   ptr_q,    ptr_d;
    logic [N_REQ-1:0] gnt_q,    gnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [3:0]       hits_q,   hits_d;

    logic             cur_bit;
    logic             hit;
    det_t             det_nxt;
    logic             found;
    logic [IDW-1:0]   win;
    int               idx;

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.hits    = hits_q;

    // Round-robin: search starts one past the last served requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    // Mealy run detector: hit on every bit from the 4th equal bit in a row.
    assign cur_bit = shreg_q[0];
    always_comb begin
        det_nxt = D_INIT;
        hit     = 1'b0;
        case (det_q)
            D_INIT:  det_nxt = cur_bit ? D_ONE1 : D_ZERO1;
            D_ONE1:  det_nxt = cur_bit ? D_ONE2 : D_ZERO1;
            D_ONE2:  det_nxt = cur_bit ? D_ONE3 : D_ZERO1;
            D_ONE3: begin
                det_nxt = cur_bit ? D_ONE3 : D_ZERO1;
                hit     = cur_bit;
            end
            D_ZERO1: det_nxt = cur_bit ? D_ONE1 : D_ZERO2;
            D_ZERO2: det_nxt = cur_bit ? D_ONE1 : D_ZERO3;
            D_ZERO3: begin
                det_nxt = cur_bit ? D_ONE1 : D_ZERO3;
                hit     = !cur_bit;
            end
            default: begin
                det_nxt = D_INIT;
                hit     = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        det_d     = det_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        hits_d    = hits_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_SHIFT;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    busy_d     = 1'b1;
                    shreg_d    = bus.data[int'(win)*WIDTH +: WIDTH];
                    bitcnt_d   = '0;
                    cnt_d      = '0;
                    det_d      = D_INIT;
                    ptr_d      = win;
                end
            end
            S_SHIFT: begin
                det_d    = det_nxt;
                shreg_d  = shreg_q >> 1;
                bitcnt_d = bitcnt_q + BCW'(1);
                cnt_d    = cnt_q + {3'b000, hit};
                if (bitcnt_q == BCW'(WIDTH - 1)) begin
                    // Last bit: its hit must be folded into the reported count.
                    state_d   = S_DONE;
                    gnt_d     = '0;
                    done_d    = 1'b1;
                    hits_d    = cnt_q + {3'b000, hit};
                    done_id_d = ptr_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= S_IDLE;
            det_q     <= D_INIT;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            cnt_q     <= '0;
            ptr_q     <= IDW'(N_REQ - 1);
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            hits_q    <= '0;
        end else begin
            state_q   <= state_d;
            det_q     <= det_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            hits_q    <= hits_d;
        end
    end
endmodule

// File: tb/tb_run_detect_arbiter.sv
module tb_run_detect_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 10;

    logic clk = 1'b0;
    logic nreset;
    always #(T/2) clk = ~clk;

    run_detect_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();

    run_detect_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .CLK    (clk),
        .nRESET (nreset),
        .bus    (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int m_ptr;
    logic [W-1:0] words [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_words();
        for (int k = 0; k < N; k++) bus.data[k*W +: W] = words[k];
    endtask

    // Round-robin reference: first requester after the last served one.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 1; i <= N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // Reference hit count: number of bits whose current equal-bit run length is >= 4.
    function automatic int ref_hits(input logic [W-1:0] w);
        int run = 0;
        int cnt = 0;
        for (int i = 0; i < W; i++) begin
            if (i > 0 && w[i] == w[i-1]) run++;
            else run = 1;
            if (run >= 4) cnt++;
        end
        return cnt;
    endfunction

    // One full service, starting with the DUT idle and req set before the next edge.
    task automatic serve(input string tag, input int drop_at,
                         output int got_id, output int got_hits, output time t_done);
        int  ew, eh;
        time t0;
        ew = pick(bus.req, m_ptr);
        if (ew < 0) ew = 0;
        eh = ref_hits(words[ew]);
        @(posedge clk); @(negedge clk);
        chk({tag, "_gnt"},  32'(bus.gnt), 32'(1 << ew));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        t0    = $time;
        m_ptr = ew;
        for (int c = 1; c < W; c++) begin
            if (c == drop_at) bus.req[ew] = 1'b0;
            @(negedge clk);
            chk({tag, "_gnt_hold"}, 32'(bus.gnt), 32'(1 << ew));
            chk({tag, "_done_early"}, 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_done"},    32'(bus.done), 32'd1);
        chk({tag, "_gnt_off"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_busy_dn"}, 32'(bus.busy), 32'd1);
        chk({tag, "_id"},      32'(bus.done_id), 32'(ew));
        chk({tag, "_hits"},    32'(bus.hits), 32'(eh));
        chk({tag, "_lat"},     32'($time - t0), 32'(W * T));
        got_id   = int'(bus.done_id);
        got_hits = int'(bus.hits);
        t_done   = $time;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"},       32'(bus.busy), 32'd0);
        chk({tag, "_hits_hold"},  32'(bus.hits), 32'(eh));
    endtask

    initial begin
        int  gid, gh;
        time td, tprev;
        int  order [5];
        order = '{0, 1, 2, 3, 0};

        nreset   = 1'b0;
        bus.req  = '0;
        bus.data = '0;
        for (int k = 0; k < N; k++) words[k] = '0;
        m_ptr = N - 1;
        #1;
        chk("rst_gnt",  32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_id",   32'(bus.done_id), 32'd0);
        chk("rst_hits", 32'(bus.hits), 32'd0);
        @(negedge clk); @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // 1: all ones
        words[0] = 8'hFF; apply_words(); bus.req = 4'b0001;
        serve("t1", -1, gid, gh, td);
        chk("t1_hits_const", 32'(gh), 32'd5);
        // 2: run of ones then run of zeros
        words[0] = 8'h0F; apply_words();
        serve("t2", -1, gid, gh, td);
        chk("t2_hits_const", 32'(gh), 32'd2);
        // 3: alternating, then all zeros
        words[0] = 8'hAA; apply_words();
        serve("t3a", -1, gid, gh, td);
        chk("t3a_hits_const", 32'(gh), 32'd0);
        words[0] = 8'h00; apply_words();
        serve("t3b", -1, gid, gh, td);
        chk("t3b_hits_const", 32'(gh), 32'd5);

        // 4: all requests held from reset
        @(negedge clk);
        nreset = 1'b0;
        words[0] = 8'hFF; words[1] = 8'h0F; words[2] = 8'h3C; words[3] = 8'hF1;
        apply_words(); bus.req = 4'b1111;
        @(negedge clk);
        nreset = 1'b1; m_ptr = N - 1;
        tprev = 0;
        for (int i = 0; i < 5; i++) begin
            serve("t4", -1, gid, gh, td);
            chk("t4_order", 32'(gid), 32'(order[i]));
            if (i > 0) chk("t4_period", 32'(td - tprev), 32'((W + 2) * T));
            tprev = td;
        end

        // 5: only req1 and req3; then req1 drops mid-shift
        bus.req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            serve("t5", -1, gid, gh, td);
            chk("t5_alt", 32'(gid), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        serve("t5_drop", 3, gid, gh, td);
        chk("t5_drop_id", 32'(gid), 32'd1);
        serve("t5_after", -1, gid, gh, td);
        chk("t5_after_id", 32'(gid), 32'd3);

        // 6: reset during bit 3
        bus.req = 4'b0001; words[0] = 8'hF0; apply_words();
        @(posedge clk);
        repeat (4) @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("t6_gnt",  32'(bus.gnt), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        chk("t6_no_done", 32'(bus.done), 32'd0);
        nreset = 1'b1; m_ptr = N - 1;
        serve("t6_resume", -1, gid, gh, td);
        chk("t6_id",   32'(gid), 32'd0);
        chk("t6_hits", 32'(gh), 32'd2);

        // Random traffic against the reference model
        for (int it = 0; it < 40; it++) begin
            bus.req = '0;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("rnd_idle_gnt",  32'(bus.gnt), 32'd0);
                chk("rnd_idle_busy", 32'(bus.busy), 32'd0);
            end
            for (int k = 0; k < N; k++) words[k] = W'($urandom);
            apply_words();
            bus.req = N'($urandom_range(1, (1 << N) - 1));
            serve("rnd", -1, gid, gh, td);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
